se_mul_controller: RTL and testbench

Sequencer for the squeeze-excite channel-scaling multiplier array (16 lanes × 14-bit, Q7 fixed point). On a `start` it walks a channel range in beats of `NUM_INSTANCES` channels and issues buffer reads. It pulses the array's `start_flag` with a beat address, collects the array's `valid`/`out_address` results into a small skid FIFO, and writes them to the SE output buffer with a per-lane mask. Issue is credit-limited so that a stalled writeback never drops a result from the non-stallable multiplier pipeline.

---
 rtl/se_mul_controller.sv | 212 +++++++++++++++++++++
 tb/tb_se_mul_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_mul_controller.sv
// se_mul_controller
// Sequencer for the squeeze-excite channel-scaling multiplier array.
// A job walks ceil(num_ch / NUM_INSTANCES) beats from a base address. Each
// beat is one buffer read, then one array start a cycle later. Array results
// go through a small skid FIFO to the SE output buffer, with a per-lane
// write mask. The credit rule (fifo_count + inflight < FIFO_DEPTH) means a
// stalled writeback never drops a result from the non-stallable array.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_start, i_num_ch,    job request, sampled only in IDLE
//   i_base_addr
//   o_buf_rd_en/addr      feature/weight buffer read (1-cycle latency)
//   o_mul_start/in_addr   array start_flag / in_address
//   i_mul_valid/out_addr/ array valid / out_address / Mul_result
//   i_mul_result
//   o_wr_en/addr/data/    output buffer write, accepted on i_wr_ready
//   o_wr_mask, i_wr_ready
//   o_busy, o_done        job status, done is a one-cycle pulse
//   o_err_ovf             sticky: result arrived with the FIFO full
//   o_stall_cycles        stall counter, 0 unless SE_CTRL_PERF_CNT_EN
//
// Build option: define SE_CTRL_PERF_CNT_EN to include the stall counter.

module se_mul_controller #(
    parameter int unsigned bitsize       = 14,
    parameter int unsigned FRAC_BITS     = 7,
    parameter int unsigned NUM_INSTANCES = 16,
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [15:0]                       i_num_ch,
    input  logic [ADDR_W-1:0]                 i_base_addr,
    output logic                              o_buf_rd_en,
    output logic [ADDR_W-1:0]                 o_buf_rd_addr,
    output logic                              o_mul_start,
    output logic [ADDR_W-1:0]                 o_mul_in_address,
    input  logic                              i_mul_valid,
    input  logic [ADDR_W-1:0]                 i_mul_out_address,
    input  logic [bitsize*NUM_INSTANCES-1:0]  i_mul_result,
    output logic                              o_wr_en,
    input  logic                              i_wr_ready,
    output logic [ADDR_W-1:0]                 o_wr_addr,
    output logic [bitsize*NUM_INSTANCES-1:0]  o_wr_data,
    output logic [NUM_INSTANCES-1:0]          o_wr_mask,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_err_ovf,
    output logic [31:0]                       o_stall_cycles
);

    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned SumW  = CntW + 1;
    localparam int unsigned RemW  = (NUM_INSTANCES > 1) ? $clog2(NUM_INSTANCES) : 1;
    localparam int unsigned DataW = bitsize * NUM_INSTANCES;
    localparam int unsigned NbW   = 17;

    if (FRAC_BITS >= bitsize || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_params
        $error("se_mul_controller: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                   r_state, w_state_next;
    logic [NbW-1:0]           w_nb;
    logic [NbW-1:0]           r_reads_left;
    logic [RemW-1:0]          r_rem;
    logic [ADDR_W-1:0]        r_last_addr, r_rd_addr, r_mul_addr;
    logic                     r_mul_start, r_err_ovf;
    logic [CntW-1:0]          r_count, r_inflight;
    logic [PtrW-1:0]          r_wptr, r_rptr;
    logic [DataW-1:0]         r_fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]        r_fifo_addr [FIFO_DEPTH];
    logic [NUM_INSTANCES-1:0] r_fifo_mask [FIFO_DEPTH];

    logic                     w_start_acc, w_credit, w_rd_en, w_valid_acc, w_dec;
    logic                     w_push, w_pop, w_full, w_empty;
    logic [NUM_INSTANCES-1:0] w_push_mask;

    assign w_nb        = (NbW'(i_num_ch) + NbW'(NUM_INSTANCES - 1)) / NbW'(NUM_INSTANCES);
    assign w_start_acc = (r_state == StIdle) && i_start;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CntW'(FIFO_DEPTH));
    assign w_credit    = (SumW'(r_count) + SumW'(r_inflight)) < SumW'(FIFO_DEPTH);
    // Results arriving in IDLE belong to an aborted job and are dropped.
    assign w_valid_acc = i_mul_valid && (r_state != StIdle);
    assign w_dec       = w_valid_acc && (r_inflight != '0);
    assign w_push      = w_valid_acc && !w_full;
    assign w_pop       = !w_empty && i_wr_ready;

    always_comb begin
        w_push_mask = '1;
        if (i_mul_out_address == r_last_addr && r_rem != '0) begin
            w_push_mask = (NUM_INSTANCES'(1) << r_rem) - NUM_INSTANCES'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        unique case (r_state)
            StIdle: begin
                // An empty job goes through DRAIN, which is already satisfied,
                // so done lands two cycles after start.
                if (i_start) w_state_next = (w_nb == '0) ? StDrain : StIssue;
            end
            StIssue: begin
                w_rd_en = w_credit;
                if (w_credit && r_reads_left == NbW'(1)) w_state_next = StDrain;
            end
            StDrain: begin
                if (r_inflight == '0 && w_empty) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_reads_left <= '0;
            r_rem        <= '0;
            r_last_addr  <= '0;
            r_rd_addr    <= '0;
            r_mul_addr   <= '0;
            r_mul_start  <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_count      <= '0;
            r_inflight   <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mul_start <= w_rd_en;
            if (w_start_acc) begin
                r_reads_left <= w_nb;
                r_rem        <= RemW'(i_num_ch % 16'(NUM_INSTANCES));
                r_last_addr  <= i_base_addr + ADDR_W'(w_nb) - ADDR_W'(1);
                r_rd_addr    <= i_base_addr;
            end else if (w_rd_en) begin
                r_reads_left <= r_reads_left - NbW'(1);
                r_rd_addr    <= r_rd_addr + ADDR_W'(1);
            end
            if (w_rd_en) r_mul_addr <= r_rd_addr;
            case ({w_rd_en, w_dec})
                2'b10:   r_inflight <= r_inflight + CntW'(1);
                2'b01:   r_inflight <= r_inflight - CntW'(1);
                default: ;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: ;
            endcase
            if (w_push) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
            if (w_valid_acc && w_full) r_err_ovf <= 1'b1;
        end
    end

    // Storage is not reset; the head is gated to zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= i_mul_result;
            r_fifo_addr[r_wptr] <= i_mul_out_address;
            r_fifo_mask[r_wptr] <= w_push_mask;
        end
    end

    assign o_buf_rd_en      = w_rd_en;
    assign o_buf_rd_addr    = r_rd_addr;
    assign o_mul_start      = r_mul_start;
    assign o_mul_in_address = r_mul_addr;
    assign o_wr_en          = !w_empty;
    assign o_wr_addr        = w_empty ? '0 : r_fifo_addr[r_rptr];
    assign o_wr_data        = w_empty ? '0 : r_fifo_data[r_rptr];
    assign o_wr_mask        = w_empty ? '0 : r_fifo_mask[r_rptr];
    assign o_busy           = (r_state != StIdle);
    assign o_done           = (r_state == StDone);
    assign o_err_ovf        = r_err_ovf;

`ifdef SE_CTRL_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [1:0]  w_stall_inc;
    logic [32:0] w_stall_sum;

    assign w_stall_inc = {1'b0, (r_state == StIssue) && !w_credit}
                       + {1'b0, !w_empty && !i_wr_ready};
    assign w_stall_sum = {1'b0, r_stall_cycles} + 33'(w_stall_inc);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
        end else begin
            r_stall_cycles <= w_stall_sum[32] ? '1 : w_stall_sum[31:0];
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_se_mul_controller.sv
// Directed bench for se_mul_controller with a fixed-latency array model.
module tb_se_mul_controller;

    localparam int unsigned Bitsize = 14;
    localparam int unsigned NumInst = 16;
    localparam int unsigned AddrW   = 13;
    localparam int unsigned DataW   = Bitsize * NumInst;
    localparam int unsigned Lat     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        num_ch;
    logic [AddrW-1:0]   base_addr;
    logic               buf_rd_en;
    logic [AddrW-1:0]   buf_rd_addr;
    logic               mul_start;
    logic [AddrW-1:0]   mul_in_address;
    logic               mul_valid;
    logic [AddrW-1:0]   mul_out_address;
    logic [DataW-1:0]   mul_result;
    logic               wr_en;
    logic               wr_ready;
    logic [AddrW-1:0]   wr_addr;
    logic [DataW-1:0]   wr_data;
    logic [NumInst-1:0] wr_mask;
    logic               busy;
    logic               done;
    logic               err_ovf;
    logic [31:0]        stall_cycles;

    se_mul_controller #(
        .bitsize      (Bitsize),
        .FRAC_BITS    (7),
        .NUM_INSTANCES(NumInst),
        .ADDR_W       (AddrW),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_num_ch         (num_ch),
        .i_base_addr      (base_addr),
        .o_buf_rd_en      (buf_rd_en),
        .o_buf_rd_addr    (buf_rd_addr),
        .o_mul_start      (mul_start),
        .o_mul_in_address (mul_in_address),
        .i_mul_valid      (mul_valid),
        .i_mul_out_address(mul_out_address),
        .i_mul_result     (mul_result),
        .o_wr_en          (wr_en),
        .i_wr_ready       (wr_ready),
        .o_wr_addr        (wr_addr),
        .o_wr_data        (wr_data),
        .o_wr_mask        (wr_mask),
        .o_busy           (busy),
        .o_done           (done),
        .o_err_ovf        (err_ovf),
        .o_stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    // Distinct per-lane payload derived from the beat address.
    function automatic logic [DataW-1:0] res_of(input logic [AddrW-1:0] a);
        logic [DataW-1:0] r;
        r = '0;
        for (int i = 0; i < NumInst; i++) begin
            r[i*Bitsize +: Bitsize] = Bitsize'(a) + Bitsize'(i * 37);
        end
        return r;
    endfunction

    // Array model: start_flag with in_address emerges Lat cycles later.
    logic [Lat-1:0]   pipe_v = '0;
    logic [AddrW-1:0] pipe_a [Lat];
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[Lat-2:0], mul_start};
        pipe_a[0] <= mul_in_address;
        for (int i = 1; i < Lat; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign mul_valid       = pipe_v[Lat-1];
    assign mul_out_address = pipe_a[Lat-1];
    assign mul_result      = res_of(pipe_a[Lat-1]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity log, sampled on the falling edge.
    logic [AddrW-1:0]   rd_q [$];
    logic [AddrW-1:0]   wa_q [$];
    logic [NumInst-1:0] wm_q [$];
    logic [DataW-1:0]   wd_q [$];
    int rd_first, rd_last, ms_first, wr_first, done_cnt, done_cyc, busy_cnt, t0;

    always @(negedge clk) begin
        if (buf_rd_en) begin
            rd_q.push_back(buf_rd_addr);
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
        end
        if (mul_start && ms_first < 0) ms_first = cyc;
        if (wr_en && wr_ready) begin
            wa_q.push_back(wr_addr);
            wm_q.push_back(wr_mask);
            wd_q.push_back(wr_data);
            if (wr_first < 0) wr_first = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rd_q.delete();
        wa_q.delete();
        wm_q.delete();
        wd_q.delete();
        rd_first = -1;
        rd_last  = -1;
        ms_first = -1;
        wr_first = -1;
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
    endtask

    task automatic start_job(input logic [15:0] nc, input logic [AddrW-1:0] ba);
        clear_log();
        @(posedge clk); #1;
        start     = 1'b1;
        num_ch    = nc;
        base_addr = ba;
        t0        = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
        num_ch    = 16'($urandom);
        base_addr = AddrW'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_done_seen"}, 256'(done_cnt != 0), 256'(1));
        repeat (6) @(posedge clk);
        #1;
    endtask

    // nb and rem are worked out by hand at each call.
    task automatic check_job(input string tag, input logic [AddrW-1:0] ba, input int nb,
                             input int rem);
        logic [AddrW-1:0]   a;
        logic [NumInst-1:0] m;
        check_eq({tag, "_nrd"}, 256'(rd_q.size()), 256'(nb));
        check_eq({tag, "_nwr"}, 256'(wa_q.size()), 256'(nb));
        for (int k = 0; k < nb; k++) begin
            a = ba + AddrW'(k);
            m = (k == nb - 1 && rem != 0) ? NumInst'((1 << rem) - 1) : 16'hFFFF;
            if (k < rd_q.size())
                check_eq($sformatf("%s_rd%0d_addr", tag, k), 256'(rd_q[k]), 256'(a));
            if (k < wa_q.size()) begin
                check_eq($sformatf("%s_wr%0d_addr", tag, k), 256'(wa_q[k]), 256'(a));
                check_eq($sformatf("%s_wr%0d_mask", tag, k), 256'(wm_q[k]), 256'(m));
                check_eq($sformatf("%s_wr%0d_data", tag, k), 256'(wd_q[k]), 256'(res_of(a)));
            end
        end
        check_eq({tag, "_done_cnt"}, 256'(done_cnt), 256'(1));
        check_eq({tag, "_err_ovf"}, 256'(err_ovf), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        num_ch    = '0;
        base_addr = '0;
        wr_ready  = 1'b1;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 256'(busy), 256'(0));
        check_eq("rst_done", 256'(done), 256'(0));
        check_eq("rst_rd_en", 256'(buf_rd_en), 256'(0));
        check_eq("rst_rd_addr", 256'(buf_rd_addr), 256'(0));
        check_eq("rst_mul_start", 256'(mul_start), 256'(0));
        check_eq("rst_mul_addr", 256'(mul_in_address), 256'(0));
        check_eq("rst_wr_en", 256'(wr_en), 256'(0));
        check_eq("rst_wr_addr", 256'(wr_addr), 256'(0));
        check_eq("rst_wr_data", 256'(wr_data), 256'(0));
        check_eq("rst_wr_mask", 256'(wr_mask), 256'(0));
        check_eq("rst_err_ovf", 256'(err_ovf), 256'(0));
        check_eq("rst_stall", 256'(stall_cycles), 256'(0));
        rst = 1'b1;

        // 40 channels: 3 beats, last beat keeps 8 lanes.
        start_job(16'd40, 13'h010);
        wait_done("t1", 100);
        check_job("t1", 13'h010, 3, 8);
        check_eq("t1_rd_first", 256'(rd_first), 256'(t0 + 1));
        check_eq("t1_rd_last", 256'(rd_last), 256'(t0 + 3));
        check_eq("t1_ms_first", 256'(ms_first), 256'(t0 + 2));
        check_eq("t1_wr_first", 256'(wr_first), 256'(t0 + 2 + Lat + 1));
        check_eq("t1_busy_span", 256'(busy_cnt), 256'(done_cyc - t0));

        // 32 channels with writeback held off for 20 cycles.
        wr_ready = 1'b0;
        start_job(16'd32, 13'h020);
        repeat (19) @(posedge clk);
        #1;
        check_eq("t2_rd_held", 256'(rd_q.size()), 256'(2));
        check_eq("t2_wr_held", 256'(wa_q.size()), 256'(0));
`ifdef SE_CTRL_PERF_CNT_EN
        check_eq("t2_stall_nonzero", 256'(stall_cycles != 0), 256'(1));
`else
        check_eq("t2_stall_tied", 256'(stall_cycles), 256'(0));
`endif
        wr_ready = 1'b1;
        wait_done("t2", 100);
        check_job("t2", 13'h020, 2, 0);

        // 128 channels with writeback held: credit caps reads at FIFO depth.
        wr_ready = 1'b0;
        start_job(16'd128, 13'h800);
        repeat (19) @(posedge clk);
        #1;
        check_eq("t2b_rd_credit", 256'(rd_q.size()), 256'(4));
        check_eq("t2b_wr_held", 256'(wa_q.size()), 256'(0));
        wr_ready = 1'b1;
        wait_done("t2b", 200);
        check_job("t2b", 13'h800, 8, 0);

        // Empty job.
        start_job(16'd0, 13'h055);
        wait_done("t3", 20);
        check_eq("t3_done_cyc", 256'(done_cyc), 256'(t0 + 2));
        check_eq("t3_nrd", 256'(rd_q.size()), 256'(0));
        check_eq("t3_nwr", 256'(wa_q.size()), 256'(0));
        check_eq("t3_busy_span", 256'(busy_cnt), 256'(2));
        check_eq("t3_done_cnt", 256'(done_cnt), 256'(1));

        // Address wrap at the top of the beat space.
        start_job(16'd48, 13'h1FFF);
        wait_done("t4", 100);
        check_job("t4", 13'h1FFF, 3, 0);

        // Reset in the middle of issue, then a fresh single-beat job.
        start_job(16'd160, 13'h100);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5_busy", 256'(busy), 256'(0));
        check_eq("t5_rd_en", 256'(buf_rd_en), 256'(0));
        check_eq("t5_mul_start", 256'(mul_start), 256'(0));
        check_eq("t5_mul_addr", 256'(mul_in_address), 256'(0));
        check_eq("t5_wr_en", 256'(wr_en), 256'(0));
        check_eq("t5_wr_data", 256'(wr_data), 256'(0));
        check_eq("t5_wr_mask", 256'(wr_mask), 256'(0));
        check_eq("t5_done", 256'(done), 256'(0));
        rst = 1'b1;
        clear_log();
        repeat (8) @(posedge clk);
        #1;
        check_eq("t5_late_wr", 256'(wa_q.size()), 256'(0));
        check_eq("t5_no_done", 256'(done_cnt), 256'(0));
        check_eq("t5_idle_rd", 256'(rd_q.size()), 256'(0));
        start_job(16'd16, 13'h040);
        wait_done("t5", 100);
        check_job("t5", 13'h040, 1, 0);

        // A second start while busy must be ignored.
        start_job(16'd40, 13'h200);
        start     = 1'b1;
        num_ch    = 16'd16;
        base_addr = 13'h300;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t6", 100);
        check_job("t6", 13'h200, 3, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
